rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4:1 data mux among four requesters.

---
 rtl/rr_mux_arbiter_if.sv | 26 ++
 rtl/rr_mux_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle for rr_mux_arbiter: four req/data lanes in,
// one-hot grant, mux select and a valid-qualified data stream out.
interface rr_mux_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        req;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d3;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] y;
    logic              y_valid;
    logic              busy;

    modport master (
        output req, d0, d1, d2, d3,
        input  gnt, sel, y, y_valid, busy
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output gnt, sel, y, y_valid, busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux; each grant lasts at most HOLD_MAX beats.
// Define ARB_FIXED_PRIO_EN for fixed priority (req[0] highest) instead of round-robin.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; picks a winner from req, always one cycle after release
//   GRANT | one requester owns the mux; one beat per cycle while its req holds
module rr_mux_arbiter #(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t            state;
    logic [3:0]        gnt_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] y_q;
    logic              vld_q;
    logic              busy_q;
    logic [7:0]        cnt;
    logic [1:0]        win;
    logic [DATA_W-1:0] d_sel;
    logic              beat;
    logic              release_now;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[i]) win = 2'(i);
        end
    end
`else
    logic [1:0] ptr;
    logic [1:0] idx;

    // Scan downward so the smallest offset from ptr is the final assignment.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (bus.req[idx]) win = idx;
        end
    end
`endif

    always_comb begin
        d_sel = bus.d0;
        case (sel_q)
            2'd0: d_sel = bus.d0;
            2'd1: d_sel = bus.d1;
            2'd2: d_sel = bus.d2;
            2'd3: d_sel = bus.d3;
            default: d_sel = bus.d0;
        endcase
    end

    assign beat        = bus.req[sel_q];
    assign release_now = !beat || (cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= 4'd0;
            sel_q  <= 2'd0;
            y_q    <= '0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt    <= 8'd0;
`ifndef ARB_FIXED_PRIO_EN
            ptr    <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    vld_q <= 1'b0;
                    if (bus.req != 4'd0) begin
                        state  <= GRANT;
                        gnt_q  <= 4'd1 << win;
                        sel_q  <= win;
                        cnt    <= 8'd0;
                        busy_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        y_q   <= d_sel;
                        vld_q <= 1'b1;
                        cnt   <= cnt + 8'd1;
                    end else begin
                        vld_q <= 1'b0;
                    end
                    // sel is left as-is on release; only gnt/busy drop.
                    if (release_now) begin
                        state  <= IDLE;
                        gnt_q  <= 4'd0;
                        busy_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                        ptr    <= sel_q + 2'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = vld_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (HOLD_MAX=4 main instance, HOLD_MAX=1 side instance).
// Expected grant orders follow ARB_FIXED_PRIO_EN when it is defined.
module tb_rr_mux_arbiter;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.DATA_W(8)) bus  ();
    rr_mux_arbiter_if #(.DATA_W(8)) bus1 ();

    rr_mux_arbiter #(.DATA_W(8), .HOLD_MAX(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    rr_mux_arbiter #(.DATA_W(8), .HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    logic [7:0] dv [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] es,
                             input logic ev, input logic [7:0] ey);
        chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
        if (eg != 4'd0) chk({tag, ".sel"}, 32'(bus.sel), 32'(es));
        chk({tag, ".vld"}, 32'(bus.y_valid), 32'(ev));
        if (ev) chk({tag, ".y"}, 32'(bus.y), 32'(ey));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(eg != 4'd0));
    endtask

    // Grant edge followed by four beats; the fourth beat edge also releases.
    task automatic grant_cycle(input string tag, input int w);
        step();
        check_out({tag, ".g"}, 4'd1 << w, 2'(w), 1'b0, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out({tag, ".b"}, (k < 4) ? (4'd1 << w) : 4'd0, 2'(w), 1'b1, dv[w]);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = 4'd0;
        bus1.req = 4'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_data();
        bus.d0 = dv[0];
        bus.d1 = dv[1];
        bus.d2 = dv[2];
        bus.d3 = dv[3];
    endtask

    initial begin
        int order3 [5];
        dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
        bus.d0 = 8'h00; bus.d1 = 8'h00; bus.d2 = 8'h00; bus.d3 = 8'h00;
        bus1.d0 = 8'h5A; bus1.d1 = 8'h00; bus1.d2 = 8'h00; bus1.d3 = 8'h00;

        // 1: reset dominates pending requests
        rst = 1'b1;
        bus.req = 4'b1111;
        bus1.req = 4'b1111;
        step();
        check_out("t1a", 4'd0, 2'd0, 1'b0, 8'h00);
        chk("t1a.y", 32'(bus.y), 32'h0);
        step();
        check_out("t1b", 4'd0, 2'd0, 1'b0, 8'h00);
        bus.req = 4'd0;
        bus1.req = 4'd0;
        rst = 1'b0;
        step();
        check_out("t1idle", 4'd0, 2'd0, 1'b0, 8'h00);

        // 2: single requester re-granted after each bubble; HOLD_MAX=1 alongside
        bus.d0 = 8'hA5;
        bus.req = 4'b0001;
        bus1.req = 4'b0001;
        step();
        check_out("t2g", 4'b0001, 2'd0, 1'b0, 8'h00);
        chk("t2h1.gnt", 32'(bus1.gnt), 32'h1);
        chk("t2h1.vld", 32'(bus1.y_valid), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out("t2b", (k < 4) ? 4'b0001 : 4'd0, 2'd0, 1'b1, 8'hA5);
            chk("t2h1.gnt", 32'(bus1.gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2h1.vld", 32'(bus1.y_valid), (k % 2 == 1) ? 32'h1 : 32'h0);
            if (k % 2 == 1) chk("t2h1.y", 32'(bus1.y), 32'h5A);
        end
        step();
        check_out("t2re", 4'b0001, 2'd0, 1'b0, 8'h00);
        bus.req = 4'd0;
        bus1.req = 4'd0;
        step();
        check_out("t2drop", 4'd0, 2'd0, 1'b0, 8'h00);
        chk("t2hold.y", 32'(bus.y), 32'hA5);

        // 3: all requesting, rotation 0,1,2,3,0 with a bubble between grants
        do_reset();
        drive_data();
        order3 = FIXED ? '{0, 0, 0, 0, 0} : '{0, 1, 2, 3, 0};
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) grant_cycle("t3", order3[g]);

        // 4: early drop on requester 2 releases without a beat; next goes past 2
        do_reset();
        drive_data();
        bus.d2 = 8'h77;
        bus.req = 4'b0100;
        step();
        check_out("t4g", 4'b0100, 2'd2, 1'b0, 8'h00);
        step();
        check_out("t4b1", 4'b0100, 2'd2, 1'b1, 8'h77);
        step();
        check_out("t4b2", 4'b0100, 2'd2, 1'b1, 8'h77);
        bus.req = 4'b1001;
        step();
        check_out("t4rel", 4'd0, 2'd2, 1'b0, 8'h00);
        chk("t4rel.sel", 32'(bus.sel), 32'h2);
        step();
        check_out("t4next", FIXED ? 4'b0001 : 4'b1000, FIXED ? 2'd0 : 2'd3, 1'b0, 8'h00);

        // 5: reset mid-grant clears outputs and the rotation pointer
        do_reset();
        drive_data();
        bus.req = 4'b0011;
        grant_cycle("t5a", 0);
        step();
        check_out("t5g", FIXED ? 4'b0001 : 4'b0010, FIXED ? 2'd0 : 2'd1, 1'b0, 8'h00);
        step();
        check_out("t5b", FIXED ? 4'b0001 : 4'b0010, FIXED ? 2'd0 : 2'd1, 1'b1,
                  FIXED ? 8'h11 : 8'h22);
        rst = 1'b1;
        step();
        check_out("t5rst", 4'd0, 2'd0, 1'b0, 8'h00);
        chk("t5rst.sel", 32'(bus.sel), 32'h0);
        chk("t5rst.y", 32'(bus.y), 32'h0);
        rst = 1'b0;
        bus.req = 4'b0011;
        step();
        check_out("t5after", 4'b0001, 2'd0, 1'b0, 8'h00);

        // 6: req=1010 -> alternating 1,3 in round-robin, always 1 in fixed priority
        do_reset();
        drive_data();
        bus.req = 4'b1010;
        grant_cycle("t6a", 1);
        grant_cycle("t6b", FIXED ? 1 : 3);
        grant_cycle("t6c", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
